struct_reg_arbiter: RTL and testbench

//  Shares one struct_t configuration register between N_REQ requesters.

---
 rtl/struct_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 44 ++++
 rtl/struct_reg_arbiter.sv | 142 ++++++++++++++
 tb/tb_struct_reg_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/struct_arb_pkg.sv
// Shared types and constants for the struct register arbiter.
package struct_arb_pkg;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
    } struct_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam struct_t STRUCT_RESET = '{x: 2'h1, y: 2'h1};

    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_win,
    output logic [PW-1:0]    o_idx,
    output logic             o_valid
);

    logic [N_REQ-1:0] w_rot;
    logic [PW-1:0]    w_k;
    int               w_sum;

    // Rotate so i_ptr lands at bit 0, priority-encode, then rotate the index back.
    always_comb begin
        w_rot   = '0;
        w_k     = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_rot[i] = i_req[(i + int'(i_ptr)) % N_REQ];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_k     = PW'(i);
                o_valid = 1'b1;
            end else begin
                w_k     = w_k;
                o_valid = o_valid;
            end
        end
        w_sum = (int'(w_k) + int'(i_ptr)) % N_REQ;
        o_idx = PW'(w_sum);
        if (o_valid) begin
            o_win = N_REQ'(1) << o_idx;
        end else begin
            o_win = '0;
        end
    end

endmodule

// File: rtl/struct_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared struct_t register.
// Optional STRUCT_ARB_LOCK_EN adds i_lock to keep priority after an ack.
module struct_reg_arbiter
    import struct_arb_pkg::*;
#(
    parameter int      N_REQ     = 4,
    parameter int      WR_LAT    = 2,
    parameter struct_t RESET_VAL = STRUCT_RESET
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [4*N_REQ-1:0] i_wdata,
`ifdef STRUCT_ARB_LOCK_EN
    input  logic [N_REQ-1:0]   i_lock,
`endif
    output logic [N_REQ-1:0]   o_gnt,
    output logic [N_REQ-1:0]   o_ack,
    output logic [3:0]         o_q,
    output logic               o_busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

    state_e           r_state, w_state_nxt;
    struct_t          r_q, w_q_nxt;
    struct_t          r_stage, w_stage_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0] r_ack, w_ack_nxt;
    logic             r_busy, w_busy_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic [PW-1:0]    r_win_idx, w_win_idx_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;

    logic [N_REQ-1:0] w_pick_win;
    logic [PW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic             w_keep;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_win   (w_pick_win),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

`ifdef STRUCT_ARB_LOCK_EN
    assign w_keep = i_lock[r_win_idx];
`else
    assign w_keep = 1'b0;
`endif

    // Next-state and next-register logic for the IDLE/BUSY/ACK sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_q_nxt       = r_q;
        w_stage_nxt   = r_stage;
        w_gnt_nxt     = r_gnt;
        w_ack_nxt     = '0;
        w_busy_nxt    = r_busy;
        w_ptr_nxt     = r_ptr;
        w_win_idx_nxt = r_win_idx;
        w_cnt_nxt     = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    // wdata is captured only here; later changes are ignored.
                    w_stage_nxt   = struct_t'(i_wdata[4*int'(w_pick_idx) +: 4]);
                    w_win_idx_nxt = w_pick_idx;
                    w_gnt_nxt     = w_pick_win;
                    w_cnt_nxt     = CW'(WR_LAT - 1);
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = BUSY;
                end else begin
                    w_gnt_nxt  = '0;
                    w_busy_nxt = 1'b0;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_q_nxt     = r_stage;
                    w_ack_nxt   = r_gnt;
                    w_gnt_nxt   = '0;
                    w_state_nxt = ACK;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ACK: begin
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
                if (w_keep) begin
                    w_ptr_nxt = r_win_idx;
                end else begin
                    w_ptr_nxt = PW'(wrap_inc(int'(r_win_idx), N_REQ));
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any write in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_q       <= RESET_VAL;
            r_stage   <= RESET_VAL;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= '0;
            r_win_idx <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_q       <= w_q_nxt;
            r_stage   <= w_stage_nxt;
            r_gnt     <= w_gnt_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= w_busy_nxt;
            r_ptr     <= w_ptr_nxt;
            r_win_idx <= w_win_idx_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign o_gnt  = r_gnt;
    assign o_ack  = r_ack;
    assign o_q    = r_q;
    assign o_busy = r_busy;

endmodule

// File: tb/tb_struct_reg_arbiter.sv
// Randomized and directed bench for struct_reg_arbiter against a
// transaction-phase reference model (optionally with STRUCT_ARB_LOCK_EN).
module tb_struct_reg_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [4*N-1:0] wdata;
`ifdef STRUCT_ARB_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [3:0]     q;
    logic           busy;

    always #5 clk = ~clk;

    struct_reg_arbiter #(
        .N_REQ  (N),
        .WR_LAT (LAT)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_wdata (wdata),
`ifdef STRUCT_ARB_LOCK_EN
        .i_lock  (lock),
`endif
        .o_gnt   (gnt),
        .o_ack   (ack),
        .o_q     (q),
        .o_busy  (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 idle, 1..LAT granted, LAT+1 ack cycle.
    int           m_phase = 0;
    int           m_win   = 0;
    int           m_ptr   = 0;
    logic [3:0]   m_stage = 4'h0;
    logic [3:0]   e_q     = 4'h5;
    logic [N-1:0] e_gnt   = '0;
    logic [N-1:0] e_ack   = '0;
    logic         e_busy  = 1'b0;
    int           ack_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_phase = 0; m_ptr = 0; e_q = 4'h5;
            e_gnt = '0; e_ack = '0; e_busy = 1'b0;
        end else if (m_phase == 0) begin
            e_ack = '0;
            if (req != '0) begin
                m_win   = pick(req, m_ptr);
                m_stage = wdata[4*m_win +: 4];
                e_gnt   = N'(1) << m_win;
                e_busy  = 1'b1;
                m_phase = 1;
            end
        end else if (m_phase < LAT) begin
            m_phase++;
        end else if (m_phase == LAT) begin
            e_q     = m_stage;
            e_ack   = N'(1) << m_win;
            e_gnt   = '0;
            m_phase = LAT + 1;
        end else begin
            e_ack   = '0;
            e_busy  = 1'b0;
            m_phase = 0;
            m_ptr   = (m_win + 1) % N;
`ifdef STRUCT_ARB_LOCK_EN
            if (lock[m_win]) m_ptr = m_win;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("gnt",  32'(gnt),  32'(e_gnt));
        check("ack",  32'(ack),  32'(e_ack));
        check("q",    32'(q),    32'(e_q));
        check("busy", 32'(busy), 32'(e_busy));
        for (int i = 0; i < N; i++) begin
            if (ack[i]) ack_log.push_back(i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_log(input string tag, input int exp_seq[$]);
        check({tag, "_n"}, 32'(ack_log.size()), 32'(exp_seq.size()));
        for (int k = 0; k < exp_seq.size() && k < ack_log.size(); k++) begin
            check(tag, 32'(ack_log[k]), 32'(exp_seq[k]));
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        wdata = '0;
`ifdef STRUCT_ARB_LOCK_EN
        lock  = '0;
`endif
        @(negedge clk);
        tick();
        tick();
        check("rst_q", 32'(q), 32'h5);
        check("rst_gnt_ack_busy", 32'({gnt, ack, busy}), 32'h0);

        // Single request: two grant cycles, ack on third edge.
        rst = 1'b0;
        wdata[7:4] = 4'hA;
        req = 4'b0010;
        tick(); check("t2_gnt1", 32'(gnt), 32'h2);
        tick(); check("t2_gnt2", 32'(gnt), 32'h2);
        tick(); check("t2_ack", 32'(ack), 32'h2); check("t2_q", 32'(q), 32'hA);
        req = '0;
        tick(); check("t2_idle", 32'({ack, busy}), 32'h0);

        // Reset in the middle of a write aborts it.
        wdata[7:4] = 4'h3;
        req = 4'b0010;
        tick();
        rst = 1'b1;
        req = '0;
        tick();
        check("t1_abort_ack", 32'(ack), 32'h0);
        check("t1_abort_q", 32'(q), 32'h5);
        rst = 1'b0;
        tick(); check("t1_no_late_ack", 32'(ack), 32'h0);

        // All requesting: round-robin 0,1,2,3,0.
        do_reset();
        wdata = {4'h4, 4'h3, 4'h2, 4'h1};
        req = 4'b1111;
        ack_log.delete();
        repeat (5 * (LAT + 2)) tick();
        check_log("t3_order", '{0, 1, 2, 3, 0});
        check("t3_q", 32'(q), 32'h1);
        req = '0;
        tick();

        // Move ptr to 3, then 3 and 0 contend: 3 then wrap to 0.
        req = 4'b0100;
        repeat (LAT + 1) tick();
        req = '0;
        tick();
        req = 4'b1001;
        ack_log.delete();
        repeat (2 * (LAT + 2)) tick();
        check_log("t4_wrap", '{3, 0});
        req = '0;
        tick();

        // wdata changed and req dropped mid-write.
        wdata[3:0] = 4'h7;
        req = 4'b0001;
        tick();
        wdata[3:0] = 4'hC;
        req = '0;
        repeat (LAT) tick();
        check("t5_ack", 32'(ack), 32'h1);
        check("t5_q", 32'(q), 32'h7);
        tick();

`ifdef STRUCT_ARB_LOCK_EN
        do_reset();
        lock = 4'b0100;
        req = 4'b0110;
        ack_log.delete();
        repeat (3 * (LAT + 2)) tick();
        check_log("t6_lock", '{1, 2, 2});
        lock = '0;
        ack_log.delete();
        repeat (2 * (LAT + 2)) tick();
        check_log("t6_unlock", '{2, 1});
        req = '0;
        tick();
`endif

        // Random traffic; requesters hold until acked, sometimes drop early.
        do_reset();
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (e_ack[i]) req[i] = ($urandom_range(0, 3) == 0);
                else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
                else if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
                else req[i] = 1'b1;
            end
            wdata = 16'($urandom);
`ifdef STRUCT_ARB_LOCK_EN
            lock = 4'($urandom);
`endif
            rst = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
